// File: rtl/enc_block_sequencer_if.sv
// Handshake bundle between the input buffer / encoder core and enc_block_sequencer.
// The abort signal exists only when ENC_SEQ_ABORT_EN is defined.
interface enc_block_sequencer_if;
  logic start;
  logic mode;
  logic in_valid;
`ifdef ENC_SEQ_ABORT_EN
  logic abort;
`endif
  logic ready;
  logic in_rd;
  logic enc_en;
  logic switch;
  logic term_sel;
  logic out_valid;
  logic busy;
  logic done;

`ifdef ENC_SEQ_ABORT_EN
  modport master (
    output start, mode, in_valid, abort,
    input  ready, in_rd, enc_en, switch, term_sel, out_valid, busy, done
  );
  modport slave (
    input  start, mode, in_valid, abort,
    output ready, in_rd, enc_en, switch, term_sel, out_valid, busy, done
  );
`else
  modport master (
    output start, mode, in_valid,
    input  ready, in_rd, enc_en, switch, term_sel, out_valid, busy, done
  );
  modport slave (
    input  start, mode, in_valid,
    output ready, in_rd, enc_en, switch, term_sel, out_valid, busy, done
  );
`endif
endinterface

// File: rtl/enc_block_sequencer.sv
// Channel-encoder block sequencer: data beats, trellis tail, pipeline flush, done pulse.
// Optional abort input is compiled in when ENC_SEQ_ABORT_EN is defined.
module enc_block_sequencer #(
  parameter int unsigned LEN_SHORT = 132,
  parameter int unsigned LEN_LONG  = 768,
  parameter int unsigned TAIL_LEN  = 4,
  parameter int unsigned PIPE_LAT  = 5,
  parameter int unsigned CNT_W     = 13
) (
  input  logic                 clk,
  input  logic                 clr,
  enc_block_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    LAST_SHORT = CNT_W'(LEN_SHORT - 1);
  localparam logic [CNT_W-1:0]    LAST_LONG  = CNT_W'(LEN_LONG - 1);
  localparam logic [CNT_W-1:0]    LAST_TAIL  = CNT_W'(TAIL_LEN - 1);
  // Shift-register pattern holding only the final outstanding beat.
  localparam logic [PIPE_LAT-1:0] VSR_LAST   = PIPE_LAT'(1) << (PIPE_LAT - 1);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                len_sel;
  logic [PIPE_LAT-1:0] vsr;

  logic                abort_req;
  logic [CNT_W-1:0]    len_last;
  logic                beat_rd;
  logic                last_beat;
  logic                enc_adv;
  logic                flush_done;

`ifdef ENC_SEQ_ABORT_EN
  assign abort_req = bus.abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign len_last   = len_sel ? LAST_SHORT : LAST_LONG;
  assign beat_rd    = (state == DATA) && bus.in_valid && !abort_req;
  assign last_beat  = beat_rd && (count == len_last);
  assign enc_adv    = (beat_rd || (state == TAIL)) && !abort_req;
  assign flush_done = (state == FLUSH) && (vsr == VSR_LAST) && !abort_req;

  assign bus.ready     = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.in_rd     = beat_rd;
  assign bus.enc_en    = enc_adv;
  assign bus.switch    = last_beat;
  assign bus.term_sel  = (state == TAIL);
  assign bus.out_valid = vsr[PIPE_LAT-1];
  assign bus.done      = flush_done;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      count   <= '0;
      len_sel <= 1'b0;
      vsr     <= '0;
    end else begin
      // Truncating cast drops the oldest bit; also valid when PIPE_LAT is 1.
      if (abort_req) vsr <= '0;
      else           vsr <= PIPE_LAT'({vsr, enc_adv});

      if (abort_req) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              len_sel <= bus.mode;
              count   <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (last_beat) begin
              count <= '0;
              state <= TAIL;
            end else if (beat_rd) begin
              count <= count + 1'b1;
            end
          end
          TAIL: begin
            if (count == LAST_TAIL) begin
              count <= '0;
              state <= FLUSH;
            end else begin
              count <= count + 1'b1;
            end
          end
          FLUSH: begin
            if (flush_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_enc_block_sequencer.sv
// Directed bench for enc_block_sequencer with LEN_SHORT=3, LEN_LONG=768, TAIL_LEN=4, PIPE_LAT=5.
// Output vectors are {ready, busy, in_rd, enc_en, switch, term_sel, out_valid, done}.
module tb_enc_block_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ov_total = 0;
  int   done_total = 0;
  int   ov0, d0, n, sw_at;

  // Hand-derived per-cycle vectors, first DATA cycle onward.
  logic [7:0] t1_exp [13] = '{8'h70, 8'h70, 8'h78, 8'h54, 8'h54, 8'h56, 8'h56,
                              8'h42, 8'h42, 8'h42, 8'h42, 8'h43, 8'h80};
  logic [7:0] t3_exp [15] = '{8'h70, 8'h40, 8'h40, 8'h70, 8'h78, 8'h56, 8'h54, 8'h54,
                              8'h56, 8'h42, 8'h42, 8'h42, 8'h42, 8'h43, 8'h80};
  logic       t3_iv  [15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  enc_block_sequencer_if bus();

  enc_block_sequencer #(
    .LEN_SHORT(3),
    .LEN_LONG (768),
    .TAIL_LEN (4),
    .PIPE_LAT (5),
    .CNT_W    (13)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) ov_total++;
    if (bus.done === 1'b1) done_total++;
  end

  function automatic logic [7:0] outs();
    return {bus.ready, bus.busy, bus.in_rd, bus.enc_en, bus.switch, bus.term_sel,
            bus.out_valid, bus.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic iv, input logic [7:0] exp);
    bus.in_valid = iv;
    @(negedge clk);
    check(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.in_valid = 1'b0;
`ifdef ENC_SEQ_ABORT_EN
    bus.abort    = 1'b0;
`endif
    #12;
    check("reset_outs", 32'(outs()), 32'h80);
    clr = 1'b0;
    @(posedge clk);
    #1;

    // 1: short block, continuous input
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1; bus.mode = 1'b1;
    cyc("t1_c0", 1'b1, 8'h80);
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) cyc($sformatf("t1_c%0d", i + 1), 1'b1, t1_exp[i]);
    check("t1_beats", 32'(ov_total - ov0), 32'd7);
    check("t1_dones", 32'(done_total - d0), 32'd1);

    // 2: long block
    ov0 = ov_total; d0 = done_total; sw_at = 0;
    bus.start = 1'b1; bus.mode = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; n = 1;
    while (done_total == d0 && n < 2000) begin
      @(negedge clk);
      if (bus.switch === 1'b1 && sw_at == 0) sw_at = n;
      @(posedge clk); #1;
      n++;
    end
    check("t2_switch_cycle", 32'(sw_at), 32'd768);
    check("t2_end_cycle", 32'(n), 32'd778);
    check("t2_beats", 32'(ov_total - ov0), 32'd772);
    check("t2_dones", 32'(done_total - d0), 32'd1);

    // 3: input stall after first beat
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1; bus.mode = 1'b1;
    cyc("t3_c0", 1'b1, 8'h80);
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) cyc($sformatf("t3_c%0d", i + 1), t3_iv[i], t3_exp[i]);
    check("t3_beats", 32'(ov_total - ov0), 32'd7);
    check("t3_dones", 32'(done_total - d0), 32'd1);

    // 4: start re-pulsed and mode toggled mid-block are ignored
    ov0 = ov_total; d0 = done_total; sw_at = 0;
    bus.start = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; n = 1;
    while (done_total == d0 && n < 2000) begin
      bus.start = (n == 2);
      if (n == 2) bus.mode = 1'b0;
      @(negedge clk);
      if (n == 2) check("t4_ready_low", 32'(bus.ready), 32'd0);
      if (bus.switch === 1'b1 && sw_at == 0) sw_at = n;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("t4_switch_cycle", 32'(sw_at), 32'd3);
    check("t4_end_cycle", 32'(n), 32'd13);
    check("t4_beats", 32'(ov_total - ov0), 32'd7);
    check("t4_dones", 32'(done_total - d0), 32'd1);

    // 5: clr in TAIL, then a clean block
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1; bus.mode = 1'b1;
    cyc("t5_c0", 1'b1, 8'h80);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("t5_c%0d", i + 1), 1'b1, t1_exp[i]);
    clr = 1'b1;
    #1;
    check("t5_clr_outs", 32'(outs()), 32'h80);
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_total - d0), 32'd0);
    check("t5_no_beats", 32'(ov_total - ov0), 32'd0);
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1;
    cyc("t5r_c0", 1'b1, 8'h80);
    bus.start = 1'b0;
    for (int i = 0; i < 13; i++) cyc($sformatf("t5r_c%0d", i + 1), 1'b1, t1_exp[i]);
    check("t5r_beats", 32'(ov_total - ov0), 32'd7);
    check("t5r_dones", 32'(done_total - d0), 32'd1);

    // 6: start held high, back-to-back blocks
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1; bus.mode = 1'b1; bus.in_valid = 1'b1;
    n = 0;
    while (done_total - d0 < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("t6_end_cycle", 32'(n), 32'd26);
    check("t6_beats", 32'(ov_total - ov0), 32'd14);
    @(negedge clk);
    check("t6_idle", 32'(outs()), 32'h80);
    @(posedge clk); #1;

`ifdef ENC_SEQ_ABORT_EN
    // abort in DATA
    ov0 = ov_total; d0 = done_total;
    bus.start = 1'b1; bus.mode = 1'b1;
    cyc("ab_c0", 1'b1, 8'h80);
    bus.start = 1'b0;
    cyc("ab_c1", 1'b1, 8'h70);
    bus.abort = 1'b1;
    cyc("ab_c2", 1'b1, 8'h40);
    bus.abort = 1'b0;
    cyc("ab_c3", 1'b1, 8'h80);
    repeat (10) @(posedge clk);
    #1;
    check("ab_no_beats", 32'(ov_total - ov0), 32'd0);
    check("ab_no_done", 32'(done_total - d0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
